uart_rx_fifo: RTL and testbench

Receive-side byte buffer between `uart_rx` and the monitor state machine. Captures each completed `uart_rx` byte on the rising edge of `done` and drops bytes flagged with `error`. Presents the buffered bytes to the monitor through a first-word-fall-through pop interface. Drives the active-low UART clear-to-send from its fill level, so the controller is throttled before the buffer can overflow.

---
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between uart_rx and the monitor: edge-captures completed bytes,
// drops errored ones, exposes a first-word-fall-through pop port and drives active-low CTS.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int CTS_HEADROOM = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [DATA_BITS-1:0]     rx_byte,
    input  logic                     rx_done,
    input  logic                     rx_error,
    input  logic                     rd_en,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     cts,
    output logic                     overflow,
    output logic [7:0]               err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH = LW'(DEPTH - CTS_HEADROOM);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_done_q, r_cts, r_overflow;
    logic [7:0]           r_err_count;

    logic                 w_evt, w_pop, w_push_req, w_push, w_err_evt;
    logic [LW-1:0]        w_level_next;

    assign w_evt      = rx_done & ~r_done_q;
    assign w_err_evt  = w_evt & rx_error;
    assign w_push_req = w_evt & ~rx_error;
    assign w_pop      = rd_en & (r_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & ((r_level != FULL) | w_pop);

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // done_q and cts come out of reset high: no false capture, controller held off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_q    <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cts       <= 1'b1;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_done_q <= rx_done;
            r_level  <= w_level_next;
            r_cts    <= (w_level_next >= THRESH);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (clear) begin
                r_overflow  <= 1'b0;
                r_err_count <= '0;
            end else begin
                if (w_push_req && !w_push)              r_overflow  <= 1'b1;
                if (w_err_evt && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_byte;
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign rd_valid  = (r_level != '0);
    assign level     = r_level;
    assign cts       = r_cts;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: the driver predicts accepted bytes into a
// queue, a negedge monitor pops and compares every byte the DUT hands out.
module tb_uart_rx_fifo;
    localparam int DB = 8, DEPTH = 16, HR = 4;

    logic            clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
    logic [DB-1:0]   rx_byte = '0;
    logic            rx_done = 1'b0, rx_error = 1'b0, rd_en = 1'b0;
    logic [DB-1:0]   rd_data;
    logic            rd_valid, cts, overflow;
    logic [$clog2(DEPTH):0] level;
    logic [7:0]      err_count;

    uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .CTS_HEADROOM(HR)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .rx_byte(rx_byte),
        .rx_done(rx_done), .rx_error(rx_error), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .level(level), .cts(cts), .overflow(overflow),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    logic [DB-1:0] sb[$];
    bit  m_ovf = 0;
    int  m_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected status is derived purely from the scoreboard occupancy and model flags.
    task automatic check_state();
        chk("level",     int'(level),     sb.size());
        chk("rd_valid",  int'(rd_valid),  int'(sb.size() != 0));
        chk("cts",       int'(cts),       int'(sb.size() >= DEPTH - HR));
        chk("overflow",  int'(overflow),  int'(m_ovf));
        chk("err_count", int'(err_count), m_err);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic model_push(input logic [DB-1:0] b, input bit err, input bit pop);
        if (err) begin
            if (m_err < 255) m_err++;
        end else if (sb.size() < DEPTH || (pop && sb.size() > 0)) sb.push_back(b);
        else m_ovf = 1;
    endtask

    task automatic push(input logic [DB-1:0] b, input bit err, input int hold, input bit pop);
        rx_byte = b; rx_error = err; rx_done = 1'b1; rd_en = pop;
        model_push(b, err, pop);
        cyc();
        rd_en = 1'b0;
        repeat (hold - 1) cyc();
        rx_done = 1'b0; rx_error = 1'b0;
        cyc();
    endtask

    task automatic pop1();
        rd_en = 1'b1; cyc(); rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) pop1();
        chk("drained", int'(rd_valid), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1; m_ovf = 0; m_err = 0;
        cyc();
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && rd_en && rd_valid) begin
            if (sb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rd_unexpected actual=%0h expected=none", rd_data);
            end else begin
                chk("rd_data", int'(rd_data), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] b;
        #1;
        check_state();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        cyc();

        // Basic: three bytes with done held 3 cycles each
        push(8'h41, 0, 3, 0); push(8'h42, 0, 3, 0); push(8'h43, 0, 3, 0);
        repeat (3) pop1();

        // Flow control up to the CTS threshold, then one pop
        for (int i = 0; i < 12; i++) push(DB'($urandom), 0, 1, 0);
        pop1();
        drain();

        // Overflow: 17 pushes, 16 kept
        for (int i = 0; i < 17; i++) push(DB'(i + 1), 0, 1, 0);
        chk("ovf_level", int'(level), 16);
        drain();

        // Error drop and saturation
        push(8'h55, 1, 1, 0); push(8'hAA, 0, 1, 0);
        chk("err_one", int'(err_count), 1);
        drain();
        for (int i = 0; i < 300; i++) push(DB'($urandom), 1, 1, 0);
        chk("err_sat", int'(err_count), 255);
        do_clear();

        // Full with same-cycle push+pop, then empty with same-cycle push+pop
        for (int i = 0; i < DEPTH; i++) push(DB'($urandom), 0, 1, 0);
        push(8'hC3, 0, 1, 1);
        chk("full_pp_level", int'(level), 16);
        drain();
        push(8'h3C, 0, 1, 1);
        chk("empty_pp_level", int'(level), 1);
        drain();

        // Pointer wrap: 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            push(DB'($urandom), 0, 1, 0);
            pop1();
        end

        // Random mix of pushes, errored bytes, concurrent and standalone pops
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) pop1();
            else push(DB'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 3),
                      bit'($urandom_range(0, 1)));
        end
        drain();
        do_clear();

        // Asynchronous reset mid-burst with done still high
        for (int i = 0; i < 5; i++) push(DB'($urandom), 0, 1, 0);
        b = 8'h99;
        rx_byte = b; rx_done = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_cts", int'(cts), 1);
        sb.delete(); m_ovf = 0; m_err = 0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1 chk("rel_cts", int'(cts), 1);
        repeat (3) cyc();
        rx_done = 1'b0;
        cyc();
        push(8'h5A, 0, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
